axi4_rd_engine: RTL and testbench
=================================

# axi4_rd_engine

AXI4 read master that turns a single (address, byte-length) read request into a sequence of INCR bursts, issues them on an AR channel and streams the returned R data out with per-request framing. It drives the master side of AXI4_A_IF (AR use) and AXI4_R_IF, sitting directly upstream of the AXI fabric/slave. It gives DMA-style clients a simple valid/ready data stream with a completion/error status.

## Interface
Parameters:
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, R data width; BPB = DATA_WIDTH/8 bytes per beat.
- LEN_WIDTH, 16, width of request byte length.
- MAX_BURST_LEN, 16, maximum beats per burst (1..256).
- AXI_ID, 0, constant arid.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  engine idle, can accept a request.
- req_addr  in  ADDR_WIDTH  start byte address, BPB-aligned.
- req_len  in  LEN_WIDTH  byte count, multiple of BPB; 0 allowed.
- ar_if  AXI4_A_IF.master  -  read address channel.
- r_if  AXI4_R_IF.master  -  read data channel.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH  beat data.
- out_last  out  1  final beat of the request.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  error status, qualified by done_valid.

## Operation
- FSM states: IDLE, AR, R, DONE.
- IDLE: req_ready=1. On req_valid, latch addr and remain = req_len/BPB. remain==0 → DONE; else → AR.
- AR: avalid=1, aaddr=addr, alen=blen-1, asize=log2(BPB), aburst=INCR(2'b01), acache=4'b0011, aprot=0, aqos=0, aregion=0, aid=AXI_ID.
  - blen = min(remain, MAX_BURST_LEN, (4096 - addr[11:0])/BPB). blen is registered on AR entry and held stable until aready.
  - On aready: addr += blen*BPB, remain -= blen, beat_cnt = blen → R.
- R: out_valid = rvalid; rready = out_ready; out_data = rdata. Both paths are combinational in this state.
  - On rvalid & rready: beat_cnt--. err |= rresp[1]. err is also set if rlast != (beat_cnt==1).
  - beat_cnt is authoritative: the burst ends on the expected count regardless of rlast.
  - out_last = (beat_cnt==1) & (remain==0).
  - Burst end: remain==0 → DONE; else → AR.
- DONE: done_valid=1 and done_err=err for one cycle → IDLE; err cleared.
- Only one burst is outstanding at a time.
- Outside AR, avalid=0. Outside R, rready=0 and out_valid=0.

## Timing
- Reset values: state=IDLE, req_ready=1, avalid=0, rready=0, out_valid=0, out_last=0, done_valid=0, done_err=0, all counters 0. AR payload is driven to 0.
- avalid rises the cycle after request acceptance. A new AR issues the cycle after the last beat of the previous burst.
- R→out has zero latency (combinational). Data stalls follow out_ready directly.
- AR payload is stable while avalid & !aready.
- Zero-length request: done_valid asserts 1 cycle after acceptance, done_err=0.
- Reset mid-operation: all state is abandoned asynchronously. Any in-flight AXI beats after reset are the fabric's concern; no output is produced for them.

## Structure
- Package axi4_rd_pkg holds:
  - state enum.
  - AXI constants: BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, default CACHE.
  - function calc_blen(addr, remain, max).
- Sub-module axi4_burst_calc: combinational blen/4KB-boundary computation, instantiated once.

## Test plan
- Single burst: req_addr 0x1000, req_len 128 (16 beats) → one AR with aaddr 0x1000, alen 15, asize 3. Output is 16 beats with out_last only on the 16th, then done_valid with err=0.
- 4KB split: req_addr 0x0FC0, req_len 128 → AR 0x0FC0 alen 7, then AR 0x1000 alen 7. Output is 16 beats, out_last on the 16th.
- Multi-burst: req_addr 0x2000, req_len 328 (41 beats) → alens 15, 15, 8 at 0x2000, 0x2080, 0x2100.
- Backpressure: aready delayed 3 cycles, then out_ready toggled 1/0 → AR payload stable throughout. rready mirrors out_ready, no beat lost or duplicated, data order preserved.
- Error: rresp=2'b10 on beat 3 of 16 → all 16 beats forwarded, done_err=1. Separately, rlast asserted early on beat 5 → done_err=1, still 16 beats consumed.
- Reset and zero length: areset asserted in R state → outputs take reset values immediately; a subsequent req_len 0 yields done_valid the next cycle with no AR issued.

Source files
------------

// File: rtl/axi4_rd_pkg.sv
// Shared types, AXI encodings and burst-length helper for the AXI4 read engine.
package axi4_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_EXOKAY   = 2'b01;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;
    localparam logic [1:0] RESP_DECERR   = 2'b11;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // Beats in the next burst: bounded by what is left, the burst cap and the 4KB page.
    function automatic logic [8:0] calc_blen(input logic [11:0] addr_lo,
                                             input logic [31:0] remain,
                                             input logic [31:0] max_beats,
                                             input logic [3:0]  bpb_log2);
        logic [31:0] room_v;
        logic [31:0] capped_v;
        room_v   = (32'd4096 - {20'd0, addr_lo}) >> bpb_log2;
        capped_v = (max_beats < remain) ? max_beats : remain;
        capped_v = (room_v < capped_v) ? room_v : capped_v;
        return 9'(capped_v);
    endfunction

endpackage

// File: rtl/axi4_rd_if.sv
// AXI4 read-address and read-data channel bundles.
interface AXI4_A_IF #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) ();
    logic [ID_WIDTH-1:0]   aid;
    logic [ADDR_WIDTH-1:0] aaddr;
    logic [7:0]            alen;
    logic [2:0]            asize;
    logic [1:0]            aburst;
    logic [3:0]            acache;
    logic [2:0]            aprot;
    logic [3:0]            aqos;
    logic [3:0]            aregion;
    logic                  avalid;
    logic                  aready;

    modport master (output aid, aaddr, alen, asize, aburst, acache, aprot, aqos, aregion, avalid,
                    input  aready);
    modport slave  (input  aid, aaddr, alen, asize, aburst, acache, aprot, aqos, aregion, avalid,
                    output aready);
endinterface

interface AXI4_R_IF #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
) ();
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (input rid, rdata, rresp, rlast, rvalid, output rready);
    modport slave  (output rid, rdata, rresp, rlast, rvalid, input rready);
endinterface

// File: rtl/axi4_burst_calc.sv
// Combinational burst sizing that keeps every burst inside one 4KB page.
module axi4_burst_calc
    import axi4_rd_pkg::*;
#(
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16,
    parameter int BPB_LOG2      = 3
) (
    input  logic [11:0]          addr_lo,
    input  logic [LEN_WIDTH-1:0] remain,
    output logic [8:0]           blen
);

    assign blen = calc_blen(addr_lo, 32'(remain), 32'(MAX_BURST_LEN), 4'(BPB_LOG2));

endmodule

// File: rtl/axi4_rd_engine.sv
// AXI4 read master: splits one byte-length request into INCR bursts and streams R beats out.
module axi4_rd_engine
    import axi4_rd_pkg::*;
#(
    parameter int ID_WIDTH      = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BURST_LEN = 16,
    parameter int AXI_ID        = 0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    AXI4_A_IF.master              ar_if,
    AXI4_R_IF.master              r_if,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done_valid,
    output logic                  done_err
);

    localparam int BPB_LOG2 = $clog2(DATA_WIDTH / 8);

    rd_state_e             state_r, state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  remain_r;
    logic [8:0]            beat_cnt_r;
    logic [7:0]            alen_r;
    logic                  err_r;

    logic [LEN_WIDTH-1:0]  req_beats_s;
    logic [11:0]           calc_addr_s;
    logic [LEN_WIDTH-1:0]  calc_remain_s;
    logic [8:0]            blen_s;
    logic [8:0]            blen_cur_s;
    logic                  last_beat_s;
    logic                  beat_hs_s;
    logic                  unused_ok_s;

    assign req_beats_s   = req_len >> BPB_LOG2;
    // Sizing looks at the incoming request in IDLE, at the running position otherwise.
    assign calc_addr_s   = (state_r == ST_IDLE) ? req_addr[11:0] : addr_r[11:0];
    assign calc_remain_s = (state_r == ST_IDLE) ? req_beats_s : remain_r;
    assign blen_cur_s    = {1'b0, alen_r} + 9'd1;
    assign last_beat_s   = (beat_cnt_r == 9'd1);
    assign beat_hs_s     = r_if.rvalid & out_ready;
    assign unused_ok_s   = ^{r_if.rid, r_if.rresp[0]};

    axi4_burst_calc #(
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BPB_LOG2      (BPB_LOG2)
    ) u_burst_calc (
        .addr_lo (calc_addr_s),
        .remain  (calc_remain_s),
        .blen    (blen_s)
    );

    // State, position, beat counter and sticky error registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            remain_r   <= {LEN_WIDTH{1'b0}};
            beat_cnt_r <= 9'd0;
            alen_r     <= 8'd0;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r   <= req_addr;
                        remain_r <= req_beats_s;
                        if (blen_s != 9'd0) begin
                            alen_r <= blen_s[7:0] - 8'd1;
                        end
                    end
                end
                ST_AR: begin
                    if (ar_if.aready) begin
                        addr_r     <= addr_r + (ADDR_WIDTH'(blen_cur_s) << BPB_LOG2);
                        remain_r   <= remain_r - LEN_WIDTH'(blen_cur_s);
                        beat_cnt_r <= blen_cur_s;
                    end
                end
                ST_R: begin
                    if (beat_hs_s) begin
                        beat_cnt_r <= beat_cnt_r - 9'd1;
                        err_r      <= err_r | r_if.rresp[1] | (r_if.rlast != last_beat_s);
                        // Latch the next burst size as we leave for AR.
                        if (last_beat_s && (remain_r != {LEN_WIDTH{1'b0}})) begin
                            alen_r <= blen_s[7:0] - 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    err_r <= 1'b0;
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    // Next-state and per-state handshake/stream decode
    always_comb begin
        state_s      = state_r;
        req_ready    = 1'b0;
        ar_if.avalid = 1'b0;
        r_if.rready  = 1'b0;
        out_valid    = 1'b0;
        out_data     = {DATA_WIDTH{1'b0}};
        out_last     = 1'b0;
        done_valid   = 1'b0;
        done_err     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_s = (req_beats_s == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_AR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_AR: begin
                ar_if.avalid = 1'b1;
                if (ar_if.aready) begin
                    state_s = ST_R;
                end else begin
                    state_s = ST_AR;
                end
            end
            ST_R: begin
                out_valid   = r_if.rvalid;
                r_if.rready = out_ready;
                out_data    = r_if.rdata;
                out_last    = last_beat_s & (remain_r == {LEN_WIDTH{1'b0}});
                if (beat_hs_s && last_beat_s) begin
                    state_s = (remain_r == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_AR;
                end else begin
                    state_s = ST_R;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                done_err   = err_r;
                state_s    = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // AR payload: live only while the address is being offered, zero otherwise
    always_comb begin
        if (state_r == ST_AR) begin
            ar_if.aid     = ID_WIDTH'(AXI_ID);
            ar_if.aaddr   = addr_r;
            ar_if.alen    = alen_r;
            ar_if.asize   = 3'(BPB_LOG2);
            ar_if.aburst  = BURST_INCR;
            ar_if.acache  = CACHE_DEFAULT;
        end else begin
            ar_if.aid     = {ID_WIDTH{1'b0}};
            ar_if.aaddr   = {ADDR_WIDTH{1'b0}};
            ar_if.alen    = 8'd0;
            ar_if.asize   = 3'd0;
            ar_if.aburst  = 2'b00;
            ar_if.acache  = 4'd0;
        end
        ar_if.aprot   = 3'd0;
        ar_if.aqos    = 4'd0;
        ar_if.aregion = 4'd0;
    end

endmodule

// File: tb/tb_axi4_rd_engine.sv
// Directed bench for axi4_rd_engine: plays the AXI slave by hand and checks each step.
module tb_axi4_rd_engine;

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        done_valid;
    logic        done_err;

    int n_checks = 0;
    int n_errors = 0;
    int beat_idx = 0;

    AXI4_A_IF #(.ID_WIDTH(4), .ADDR_WIDTH(32)) ar_if ();
    AXI4_R_IF #(.ID_WIDTH(4), .DATA_WIDTH(64)) r_if ();

    axi4_rd_engine #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64),
        .LEN_WIDTH(16), .MAX_BURST_LEN(16), .AXI_ID(0)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .ar_if      (ar_if),
        .r_if       (r_if),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .done_valid (done_valid),
        .done_err   (done_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [15:0] len);
        @(negedge aclk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        #1 chk("req_ready_idle", req_ready, 1'b1);
        @(posedge aclk);
        #1 req_valid = 1'b0;
        beat_idx = 0;
    endtask

    task automatic wait_ar(input logic [31:0] exp_addr, input logic [7:0] exp_alen, input int delay);
        int w;
        w = 0;
        @(negedge aclk);
        while (ar_if.avalid !== 1'b1 && w < 20) begin
            w++;
            @(negedge aclk);
        end
        chk("ar_wait_cycles", 64'(w), 64'd0);
        if (ar_if.avalid === 1'b1) begin
            chk("ar_addr", ar_if.aaddr, exp_addr);
            chk("ar_len", ar_if.alen, exp_alen);
            chk("ar_size", ar_if.asize, 3'd3);
            chk("ar_burst", ar_if.aburst, 2'b01);
            chk("ar_cache", ar_if.acache, 4'b0011);
            chk("ar_id", ar_if.aid, 4'd0);
            chk("req_ready_busy", req_ready, 1'b0);
            for (int d = 0; d < delay; d++) begin
                @(negedge aclk);
                chk("ar_hold_valid", ar_if.avalid, 1'b1);
                chk("ar_hold_addr", ar_if.aaddr, exp_addr);
                chk("ar_hold_len", ar_if.alen, exp_alen);
            end
            ar_if.aready = 1'b1;
            @(posedge aclk);
            #1 ar_if.aready = 1'b0;
        end
    endtask

    task automatic send_beats(input int n, input bit final_burst, input bit toggle,
                              input int err_beat, input int early_beat);
        logic [63:0] exp_data;
        for (int b = 0; b < n; b++) begin
            @(negedge aclk);
            exp_data     = 64'hA5A5_0000_0000_0000 | 64'(beat_idx);
            r_if.rvalid  = 1'b1;
            r_if.rdata   = exp_data;
            r_if.rresp   = (b == err_beat) ? 2'b10 : 2'b00;
            r_if.rlast   = (b == n - 1) || (b == early_beat);
            if (toggle) begin
                out_ready = 1'b0;
                #1;
                chk("stall_rready", r_if.rready, 1'b0);
                chk("stall_out_valid", out_valid, 1'b1);
                @(negedge aclk);
            end
            out_ready = 1'b1;
            #1;
            chk("beat_valid", out_valid, 1'b1);
            chk("beat_rready", r_if.rready, 1'b1);
            chk("beat_data", out_data, exp_data);
            chk("beat_last", out_last, final_burst && (b == n - 1));
            @(posedge aclk);
            beat_idx++;
        end
        #1;
        r_if.rvalid = 1'b0;
        r_if.rlast  = 1'b0;
        r_if.rresp  = 2'b00;
    endtask

    task automatic check_done(input logic exp_err);
        @(negedge aclk);
        chk("done_valid", done_valid, 1'b1);
        chk("done_err", done_err, exp_err);
        chk("done_no_ar", ar_if.avalid, 1'b0);
        @(negedge aclk);
        chk("done_pulse_end", done_valid, 1'b0);
        chk("idle_again", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        req_valid = 1'b0;
        req_addr = 32'd0;
        req_len = 16'd0;
        out_ready = 1'b1;
        ar_if.aready = 1'b0;
        r_if.rvalid = 1'b1;
        r_if.rdata = 64'd0;
        r_if.rresp = 2'b00;
        r_if.rlast = 1'b0;
        r_if.rid = 4'd0;
        repeat (2) @(negedge aclk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_avalid", ar_if.avalid, 1'b0);
        chk("rst_rready", r_if.rready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_err", done_err, 1'b0);
        chk("rst_aaddr", ar_if.aaddr, 32'd0);
        chk("rst_alen", ar_if.alen, 8'd0);
        r_if.rvalid = 1'b0;
        areset = 1'b0;

        // Single 16-beat burst
        do_req(32'h0000_1000, 16'd128);
        wait_ar(32'h0000_1000, 8'd15, 0);
        send_beats(16, 1'b1, 1'b0, -1, -1);
        check_done(1'b0);

        // Split at the 4KB page: 8 beats before 0x1000, 8 after
        do_req(32'h0000_0FC0, 16'd128);
        wait_ar(32'h0000_0FC0, 8'd7, 0);
        send_beats(8, 1'b0, 1'b0, -1, -1);
        wait_ar(32'h0000_1000, 8'd7, 0);
        send_beats(8, 1'b1, 1'b0, -1, -1);
        check_done(1'b0);

        // 41 beats: 16 + 16 + 9
        do_req(32'h0000_2000, 16'd328);
        wait_ar(32'h0000_2000, 8'd15, 0);
        send_beats(16, 1'b0, 1'b0, -1, -1);
        wait_ar(32'h0000_2080, 8'd15, 0);
        send_beats(16, 1'b0, 1'b0, -1, -1);
        wait_ar(32'h0000_2100, 8'd8, 0);
        send_beats(9, 1'b1, 1'b0, -1, -1);
        check_done(1'b0);

        // Backpressure on both channels
        do_req(32'h0000_4000, 16'd64);
        wait_ar(32'h0000_4000, 8'd7, 3);
        send_beats(8, 1'b1, 1'b1, -1, -1);
        check_done(1'b0);

        // SLVERR on beat 3
        do_req(32'h0000_5000, 16'd128);
        wait_ar(32'h0000_5000, 8'd15, 0);
        send_beats(16, 1'b1, 1'b0, 2, -1);
        check_done(1'b1);

        // Error flag must have cleared: single-beat clean request
        do_req(32'h0000_6000, 16'd8);
        wait_ar(32'h0000_6000, 8'd0, 0);
        send_beats(1, 1'b1, 1'b0, -1, -1);
        check_done(1'b0);

        // rlast early on beat 5; beat count still governs
        do_req(32'h0000_7000, 16'd128);
        wait_ar(32'h0000_7000, 8'd15, 0);
        send_beats(16, 1'b1, 1'b0, -1, 4);
        check_done(1'b1);

        // Reset while streaming
        do_req(32'h0000_8000, 16'd128);
        wait_ar(32'h0000_8000, 8'd15, 0);
        send_beats(4, 1'b0, 1'b0, -1, -1);
        @(negedge aclk);
        r_if.rvalid = 1'b1;
        r_if.rdata  = 64'h1234_5678_9ABC_DEF0;
        out_ready   = 1'b1;
        #1 chk("pre_rst_out_valid", out_valid, 1'b1);
        areset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_rready", r_if.rready, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_avalid", ar_if.avalid, 1'b0);
        chk("mid_rst_done_valid", done_valid, 1'b0);
        r_if.rvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;

        // Zero-length request completes without an AR
        do_req(32'h0000_9000, 16'd0);
        @(negedge aclk);
        chk("zero_done_valid", done_valid, 1'b1);
        chk("zero_done_err", done_err, 1'b0);
        chk("zero_no_ar", ar_if.avalid, 1'b0);
        @(negedge aclk);
        chk("zero_done_end", done_valid, 1'b0);
        chk("zero_no_ar_after", ar_if.avalid, 1'b0);
        chk("zero_idle", req_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
